// File: rtl/hue_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : hue_sequencer_if
// Description : Control and duty-output bundle of the hue sequencer.
//               master = controller side (drives en/restart, observes duties)
//               slave  = sequencer side (consumes en/restart, drives duties)
// Signals     : en, restart          - advance enable, synchronous restart
//               duty_r/g/b [DW-1:0]  - registered PWM duty values
//               phase [2:0]          - current hue phase 0..5
//               step_tick, wrap      - one-cycle step / wheel-wrap pulses
// Revision    : 1.0 - initial release
// ============================================================================
interface hue_sequencer_if #(
    parameter int DW = 11
);
    logic          en;
    logic          restart;
    logic [DW-1:0] duty_r;
    logic [DW-1:0] duty_g;
    logic [DW-1:0] duty_b;
    logic [2:0]    phase;
    logic          step_tick;
    logic          wrap;

    modport master (
        output en,
        output restart,
        input  duty_r,
        input  duty_g,
        input  duty_b,
        input  phase,
        input  step_tick,
        input  wrap
    );

    modport slave (
        input  en,
        input  restart,
        output duty_r,
        output duty_g,
        output duty_b,
        output phase,
        output step_tick,
        output wrap
    );
endinterface
`default_nettype wire

// File: rtl/hue_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hue_sequencer
// Description : Walks an RGB duty triple around the six-phase hue wheel.
//               Every INC_DEC_INTERVAL enabled clocks one channel ramps by
//               PWM_INTERVAL/INC_DEC_MAX; after INC_DEC_MAX steps the phase
//               advances. All outputs are registered.
// Ports       : clk     - system clock (rising edge)
//               reset   - asynchronous active-high reset
//               bus     - hue_sequencer_if.slave (en, restart, duty_r/g/b,
//                         phase, step_tick, wrap); interface DW must equal
//                         $clog2(PWM_INTERVAL+1)
// Revision    : 1.0 - initial release
// ============================================================================
module hue_sequencer #(
    parameter int PWM_INTERVAL     = 1200,
    parameter int INC_DEC_MAX      = 200,
    parameter int INC_DEC_INTERVAL = 10000
) (
    input  wire logic       clk,
    input  wire logic       reset,
    hue_sequencer_if.slave  bus
);
    localparam int DW = $clog2(PWM_INTERVAL + 1);
    localparam int CW = $clog2(INC_DEC_INTERVAL);
    localparam int SW = (INC_DEC_MAX > 1) ? $clog2(INC_DEC_MAX) : 1;

    localparam logic [DW-1:0] DUTY_STEP = DW'(PWM_INTERVAL / INC_DEC_MAX);
    localparam logic [DW-1:0] DUTY_FULL = DW'(PWM_INTERVAL);
    localparam logic [CW-1:0] INT_LAST  = CW'(INC_DEC_INTERVAL - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(INC_DEC_MAX - 1);

    localparam logic [2:0] PH_G_UP   = 3'd0;
    localparam logic [2:0] PH_R_DOWN = 3'd1;
    localparam logic [2:0] PH_B_UP   = 3'd2;
    localparam logic [2:0] PH_G_DOWN = 3'd3;
    localparam logic [2:0] PH_R_UP   = 3'd4;
    localparam logic [2:0] PH_B_DOWN = 3'd5;

    // Exact landing on 0 / full scale relies on the step dividing evenly.
    generate
        if ((INC_DEC_MAX < 1) || (PWM_INTERVAL % INC_DEC_MAX != 0) ||
            (INC_DEC_INTERVAL < 2)) begin : g_param_check
            $error("hue_sequencer: illegal parameter combination");
        end
    endgenerate

    logic [2:0]    phase_q,  phase_d;
    logic [SW-1:0] step_q,   step_d;
    logic [CW-1:0] int_q,    int_d;
    logic [DW-1:0] duty_r_q, duty_r_d;
    logic [DW-1:0] duty_g_q, duty_g_d;
    logic [DW-1:0] duty_b_q, duty_b_d;
    logic          tick_q,   tick_d;
    logic          wrap_q,   wrap_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q  <= PH_G_UP;
            step_q   <= '0;
            int_q    <= '0;
            duty_r_q <= DUTY_FULL;
            duty_g_q <= '0;
            duty_b_q <= '0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            step_q   <= step_d;
            int_q    <= int_d;
            duty_r_q <= duty_r_d;
            duty_g_q <= duty_g_d;
            duty_b_q <= duty_b_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
        end
    end

    // Next-state logic
    always_comb begin
        phase_d  = phase_q;
        step_d   = step_q;
        int_d    = int_q;
        duty_r_d = duty_r_q;
        duty_g_d = duty_g_q;
        duty_b_d = duty_b_q;
        tick_d   = 1'b0;
        wrap_d   = 1'b0;

        if (bus.restart) begin
            // Restart overrides a coincident step, so no pulses are emitted.
            phase_d  = PH_G_UP;
            step_d   = '0;
            int_d    = '0;
            duty_r_d = DUTY_FULL;
            duty_g_d = '0;
            duty_b_d = '0;
        end else if (bus.en) begin
            if (int_q == INT_LAST) begin
                int_d  = '0;
                tick_d = 1'b1;

                if (step_q == STEP_LAST) begin
                    step_d  = '0;
                    phase_d = (phase_q == PH_B_DOWN) ? PH_G_UP : phase_q + 3'd1;
                    wrap_d  = (phase_q == PH_B_DOWN);
                end else begin
                    step_d = step_q + SW'(1);
                end

                // Only the ramping channel moves; held channels are already
                // at their rails from the end of the previous phase.
                case (phase_q)
                    PH_G_UP:   duty_g_d = duty_g_q + DUTY_STEP;
                    PH_R_DOWN: duty_r_d = duty_r_q - DUTY_STEP;
                    PH_B_UP:   duty_b_d = duty_b_q + DUTY_STEP;
                    PH_G_DOWN: duty_g_d = duty_g_q - DUTY_STEP;
                    PH_R_UP:   duty_r_d = duty_r_q + DUTY_STEP;
                    PH_B_DOWN: duty_b_d = duty_b_q - DUTY_STEP;
                    default:   ;
                endcase
            end else begin
                int_d = int_q + CW'(1);
            end
        end
    end

    // Output logic
    always_comb begin
        bus.duty_r    = duty_r_q;
        bus.duty_g    = duty_g_q;
        bus.duty_b    = duty_b_q;
        bus.phase     = phase_q;
        bus.step_tick = tick_q;
        bus.wrap      = wrap_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_hue_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hue_sequencer
// Description : Directed self-checking bench for hue_sequencer with
//               PWM_INTERVAL=12, INC_DEC_MAX=4, INC_DEC_INTERVAL=5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hue_sequencer;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hue_sequencer_if #(.DW(DW)) bus ();

    hue_sequencer #(
        .PWM_INTERVAL     (12),
        .INC_DEC_MAX      (4),
        .INC_DEC_INTERVAL (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected state after k steps from reset (k = 0..24), hand-derived.
    logic [3:0] exp_r  [0:24] = '{12, 12,12,12,12,  9, 6, 3, 0,  0, 0, 0, 0,
                                   0, 0, 0, 0,  3, 6, 9,12, 12,12,12,12};
    logic [3:0] exp_g  [0:24] = '{ 0,  3, 6, 9,12, 12,12,12,12, 12,12,12,12,
                                   9, 6, 3, 0,  0, 0, 0, 0,  0, 0, 0, 0};
    logic [3:0] exp_b  [0:24] = '{ 0,  0, 0, 0, 0,  0, 0, 0, 0,  3, 6, 9,12,
                                  12,12,12,12, 12,12,12,12,  9, 6, 3, 0};
    logic [2:0] exp_ph [0:24] = '{ 0,  0, 0, 0, 1,  1, 1, 1, 2,  2, 2, 2, 3,
                                   3, 3, 3, 4,  4, 4, 4, 5,  5, 5, 5, 0};

    // {r, g, b, phase, step_tick, wrap}
    function automatic logic [16:0] exp_vec(input int k, input bit tk, input bit wr);
        return {exp_r[k], exp_g[k], exp_b[k], exp_ph[k], tk, wr};
    endfunction

    function automatic logic [16:0] obs_vec();
        return {bus.duty_r, bus.duty_g, bus.duty_b, bus.phase, bus.step_tick, bus.wrap};
    endfunction

    // Reset held across two falling edges, released on a falling edge so the
    // next rising edge is clock 1.
    task automatic apply_reset(input bit en_after);
        reset       = 1'b1;
        bus.en      = 1'b0;
        bus.restart = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.en = en_after;
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] got;
        reset       = 1'b1;
        bus.en      = 1'b1;
        bus.restart = 1'b0;
        repeat (3) @(negedge clk);
        got = obs_vec();
        vectors++;
        if (got !== exp_vec(0, 1'b0, 1'b0)) begin
            $display("FAIL reset_state: got %h want %h", got, exp_vec(0, 1'b0, 1'b0));
            miscompares++;
        end
    endtask

    task automatic test_ramp();
        logic [16:0] got;
        apply_reset(1'b1);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            got = obs_vec();
            if (n == 4 || n == 5 || n == 19 || n == 20) begin
                vectors++;
                if (got !== exp_vec(n / 5, (n % 5) == 0, 1'b0)) begin
                    $display("FAIL ramp_clk%0d: got %h want %h", n, got,
                             exp_vec(n / 5, (n % 5) == 0, 1'b0));
                    miscompares++;
                end
            end
        end
    endtask

    task automatic test_full_cycle();
        logic [16:0] got;
        logic [16:0] want;
        logic [11:0] prev;
        logic [11:0] cur;
        apply_reset(1'b1);
        prev = {bus.duty_r, bus.duty_g, bus.duty_b};
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            got  = obs_vec();
            want = exp_vec(n / 5, (n % 5) == 0, n == 120);
            cur  = {bus.duty_r, bus.duty_g, bus.duty_b};
            vectors++;
            if (got !== want) begin
                $display("FAIL cycle_clk%0d: got %h want %h", n, got, want);
                miscompares++;
            end
            vectors++;
            if (bus.duty_r > 4'd12 || bus.duty_g > 4'd12 || bus.duty_b > 4'd12) begin
                $display("FAIL range_clk%0d: got r=%0d g=%0d b=%0d want <=12", n,
                         bus.duty_r, bus.duty_g, bus.duty_b);
                miscompares++;
            end
            vectors++;
            if (bus.step_tick !== 1'b1 && cur !== prev) begin
                $display("FAIL change_no_tick_clk%0d: got %h want %h", n, cur, prev);
                miscompares++;
            end
            prev = cur;
        end
    endtask

    task automatic test_pause();
        logic [16:0] got;
        apply_reset(1'b1);
        repeat (3) @(negedge clk);          // interval counter now 3
        bus.en = 1'b0;
        for (int n = 4; n <= 10; n++) begin
            @(negedge clk);
            got = obs_vec();
            vectors++;
            if (got !== exp_vec(0, 1'b0, 1'b0)) begin
                $display("FAIL pause_clk%0d: got %h want %h", n, got, exp_vec(0, 1'b0, 1'b0));
                miscompares++;
            end
        end
        bus.en = 1'b1;
        @(negedge clk);                     // clock 11: counter 3 -> 4
        got = obs_vec();
        vectors++;
        if (got !== exp_vec(0, 1'b0, 1'b0)) begin
            $display("FAIL pause_resume_clk11: got %h want %h", got, exp_vec(0, 1'b0, 1'b0));
            miscompares++;
        end
        @(negedge clk);                     // clock 12: delayed first step
        got = obs_vec();
        vectors++;
        if (got !== exp_vec(1, 1'b1, 1'b0)) begin
            $display("FAIL pause_step_clk12: got %h want %h", got, exp_vec(1, 1'b1, 1'b0));
            miscompares++;
        end
    endtask

    task automatic test_restart();
        logic [16:0] got;
        apply_reset(1'b1);
        repeat (64) @(negedge clk);         // phase 3, step 13 due at clock 65
        got = obs_vec();
        vectors++;
        if (got !== exp_vec(12, 1'b0, 1'b0)) begin
            $display("FAIL restart_pre_clk64: got %h want %h", got, exp_vec(12, 1'b0, 1'b0));
            miscompares++;
        end
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        got = obs_vec();
        vectors++;
        if (got !== exp_vec(0, 1'b0, 1'b0)) begin
            $display("FAIL restart_wins: got %h want %h", got, exp_vec(0, 1'b0, 1'b0));
            miscompares++;
        end
        repeat (4) @(negedge clk);
        got = obs_vec();
        vectors++;
        if (got !== exp_vec(0, 1'b0, 1'b0)) begin
            $display("FAIL restart_idle4: got %h want %h", got, exp_vec(0, 1'b0, 1'b0));
            miscompares++;
        end
        @(negedge clk);
        got = obs_vec();
        vectors++;
        if (got !== exp_vec(1, 1'b1, 1'b0)) begin
            $display("FAIL restart_first_step: got %h want %h", got, exp_vec(1, 1'b1, 1'b0));
            miscompares++;
        end
    endtask

    task automatic test_async_reset();
        logic [16:0] got;
        apply_reset(1'b1);
        repeat (82) @(negedge clk);         // mid phase 4
        got = obs_vec();
        vectors++;
        if (got !== exp_vec(16, 1'b0, 1'b0)) begin
            $display("FAIL async_pre_clk82: got %h want %h", got, exp_vec(16, 1'b0, 1'b0));
            miscompares++;
        end
        #2 reset = 1'b1;                    // between edges
        #1;
        got = obs_vec();
        vectors++;
        if (got !== exp_vec(0, 1'b0, 1'b0)) begin
            $display("FAIL async_immediate: got %h want %h", got, exp_vec(0, 1'b0, 1'b0));
            miscompares++;
        end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            got = obs_vec();
            if (n >= 4) begin
                vectors++;
                if (got !== exp_vec(n / 5, (n % 5) == 0, 1'b0)) begin
                    $display("FAIL async_release_clk%0d: got %h want %h", n, got,
                             exp_vec(n / 5, (n % 5) == 0, 1'b0));
                    miscompares++;
                end
            end
        end
    endtask

    initial begin
        bus.en      = 1'b0;
        bus.restart = 1'b0;
        test_reset();
        test_ramp();
        test_full_cycle();
        test_pause();
        test_restart();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/hue_sequencer.md
HUE_SEQUENCER -- requirements
Module: hue_sequencer

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1200, meaning the full-scale duty value (PWM period in clocks) of the downstream PWM stage.
REQ-002 SHALL have parameter INC_DEC_MAX, default 200, meaning the number of duty steps per hue phase.
REQ-003 SHALL have parameter INC_DEC_INTERVAL, default 10000, meaning clocks between duty steps.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port en, input, 1 bit: advance enable; when low, the sequencer pauses.
REQ-008 SHALL have port restart, input, 1 bit: synchronous return to start of hue wheel.
REQ-009 SHALL have ports duty_r, duty_g and duty_b, each an output of DW = $clog2(PWM_INTERVAL+1) bits: registered duty values for the red, green and blue PWM channels.
REQ-010 SHALL have port phase, output, 3 bits: the current hue phase, 0..5.
REQ-011 SHALL have port step_tick, output, 1 bit: a one-cycle pulse on the cycle the duty outputs change.
REQ-012 SHALL have port wrap, output, 1 bit: a one-cycle pulse coincident with step_tick when phase goes from 5 to 0.

Function
REQ-013 SHALL derive DUTY_STEP = PWM_INTERVAL / INC_DEC_MAX at elaboration and SHALL fail elaboration unless PWM_INTERVAL mod INC_DEC_MAX = 0 and INC_DEC_INTERVAL >= 2.
REQ-014 SHALL keep an interval counter 0..INC_DEC_INTERVAL-1 that increments only while en = 1; a step fires on the edge where the counter is at INC_DEC_INTERVAL-1 and en = 1, and the counter then wraps to 0.
REQ-015 SHALL keep a step counter 0..INC_DEC_MAX-1 that increments on each step; on the step where it equals INC_DEC_MAX-1, it returns to 0 and phase advances (5 wraps to 0).
REQ-016 SHALL apply phase behaviour as follows, with the ramping channel changing by exactly DUTY_STEP per step:
- Phase 0: R held at PWM_INTERVAL, G rising, B held at 0.
- Phase 1: G held at PWM_INTERVAL, R falling, B held at 0.
- Phase 2: G held at PWM_INTERVAL, B rising, R held at 0.
- Phase 3: B held at PWM_INTERVAL, G falling, R held at 0.
- Phase 4: B held at PWM_INTERVAL, R rising, G held at 0.
- Phase 5: R held at PWM_INTERVAL, B falling, G held at 0.
REQ-017 SHALL make the ramping channel land exactly on PWM_INTERVAL (rising) or 0 (falling) on the phase-final step, with no overshoot, underflow or wrap of any duty output.
REQ-018 SHALL update duty_*, phase, step_tick and wrap on the same clock edge on which the step fires; latency from the counter terminal count to the outputs is 0 extra cycles (registered outputs).
REQ-019 SHALL hold all counters and outputs while en = 0, with step_tick = 0 and wrap = 0.
REQ-020 SHALL, when restart = 1 at a clock edge, load the reset state synchronously regardless of en; when restart coincides with a step, restart wins and step_tick and wrap stay 0.
REQ-021 SHALL take 6 * INC_DEC_MAX * INC_DEC_INTERVAL enabled clocks for one full hue cycle (12,000,000 with the defaults).

Reset
REQ-022 SHALL, while reset = 1, asynchronously force phase = 0, step counter = 0, interval counter = 0, duty_r = PWM_INTERVAL, duty_g = 0, duty_b = 0, step_tick = 0 and wrap = 0.
REQ-023 SHALL, after reset deasserts with en held at 1, produce the first step_tick exactly INC_DEC_INTERVAL clocks later.
REQ-024 SHALL discard all progress when reset asserts mid-phase; there is no resume.

Verification (PWM_INTERVAL=12, INC_DEC_MAX=4, INC_DEC_INTERVAL=5, DUTY_STEP=3)
REQ-025 Reset release, en=1 -> R=12, G=0, B=0; step_tick on clock 5 with G=3; on clock 20 G=12, phase=1, R=12.
REQ-026 Run 120 clocks -> one full cycle with R/G/B sequence matching REQ-016; on clock 120 wrap=1 and step_tick=1, phase=0, R=12, G=0, B=0.
REQ-027 Drop en for 7 clocks at interval count 3 -> no output change and no tick; the next step_tick arrives 7 clocks later than without the pause.
REQ-028 Assert restart on the same edge as a pending step in phase 3 -> no step_tick; outputs return to R=12, G=0, B=0, phase=0.
REQ-029 Assert reset asynchronously mid-phase 4 (between clock edges) -> outputs take reset values immediately, without waiting for a clock edge; timing from release follows REQ-023.
REQ-030 The bench SHALL check on every cycle of a full run that each duty value stays within 0..12 and that duty outputs change only on step_tick cycles.
